screen_mirror: RTL and testbench

Shadow frame buffer that holds the colour of every on-screen pixel. It answers read requests at a pixel coordinate with a fixed 2-cycle latency; this is the read side that the screen slider and other pixel-moving engines depend on. It also captures every pixel write sent to the VGA adapter. After reset, or on request, it runs a sequencer that fills the whole buffer with one colour.

---
 rtl/screen_pkg.sv | 17 +
 rtl/screen_mirror_ram.sv | 21 ++
 rtl/screen_mirror.sv | 128 ++++++++++++
 tb/tb_screen_mirror.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared constants, FSM state type and coordinate-to-address mapping
// for the screen mirror frame buffer.
package screen_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;
  localparam int PIXELS   = SCREEN_W * SCREEN_H;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  // y*160 + x as two shifts and adds; only valid for the 160-wide screen
  function automatic logic [ADDR_W-1:0] coord_to_addr(input logic [7:0] x,
                                                      input logic [6:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction
endpackage

// File: rtl/screen_mirror_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset
// so synthesis can map it onto block RAM.
module screen_mirror_ram #(
  parameter int DEPTH  = 19200,
  parameter int DATA_W = 3,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end
endmodule

// File: rtl/screen_mirror.sv
// Shadow frame buffer: captures VGA pixel writes, serves 2-cycle-latency
// reads, and runs a whole-screen fill after reset or on clear_start.
module screen_mirror
  import screen_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          wr_x,
  input  logic [6:0]          wr_y,
  input  logic [COLOUR_W-1:0] wr_colour,
  input  logic                wr_en,
  input  logic [7:0]          rd_x,
  input  logic [6:0]          rd_y,
  output logic [COLOUR_W-1:0] rd_colour,
  input  logic                clear_start,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                busy,
  output logic                clear_done
);
  localparam logic [7:0]        X_LIM    = 8'(SCREEN_W);
  localparam logic [6:0]        Y_LIM    = 7'(SCREEN_H);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(PIXELS - 1);

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nx;
  logic [COLOUR_W-1:0] r_clr, w_clr_nx;

  logic                w_wr_ok, w_rd_ok;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr, w_raddr;
  logic [COLOUR_W-1:0] w_wdata, w_ram_q;

  // read stage 1: range bit, fill flag and same-cycle write bypass
  logic                r_rng1, r_fill1, r_hit1;
  logic [COLOUR_W-1:0] r_byp1, r_rd_colour;

  assign w_wr_ok = (wr_x < X_LIM) && (wr_y < Y_LIM);
  assign w_rd_ok = (rd_x < X_LIM) && (rd_y < Y_LIM);
  // out-of-range reads are forced to 0 so the RAM never sees an index past its end
  assign w_raddr = w_rd_ok ? coord_to_addr(rd_x, rd_y) : '0;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_clr_nx   = r_clr;
    case (r_state)
      IDLE: if (clear_start) begin
        w_state_nx = FILL;
        w_ptr_nx   = '0;
        w_clr_nx   = clear_colour;
      end
      FILL: begin
        w_ptr_nx = r_ptr + 1'b1;
        if (r_ptr == PTR_LAST) w_state_nx = DONE;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= FILL;
      r_ptr   <= '0;
      r_clr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_clr   <= w_clr_nx;
    end
  end

  // single write port shared by the fill sequencer and the VGA write bus
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!reset) begin
      if (r_state == FILL) begin
        w_we    = 1'b1;
        w_waddr = r_ptr;
        w_wdata = r_clr;
      end else if (r_state == IDLE && wr_en && !clear_start && w_wr_ok) begin
        w_we    = 1'b1;
        w_waddr = coord_to_addr(wr_x, wr_y);
        w_wdata = wr_colour;
      end
    end
  end

  screen_mirror_ram #(
    .DEPTH (PIXELS),
    .DATA_W(COLOUR_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(clock),
    .we   (w_we),
    .waddr(w_waddr),
    .wdata(w_wdata),
    .raddr(w_raddr),
    .rdata(w_ram_q)
  );

  // RAM is read-first, so a write landing on the sampled address in the
  // same cycle is forwarded from stage 1 to give write-first ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rng1      <= 1'b0;
      r_fill1     <= 1'b0;
      r_hit1      <= 1'b0;
      r_byp1      <= '0;
      r_rd_colour <= '0;
    end else begin
      r_rng1  <= w_rd_ok;
      r_fill1 <= (r_state == FILL);
      r_hit1  <= w_rd_ok && w_we && (w_waddr == w_raddr);
      r_byp1  <= w_wdata;
      if (!r_rng1)      r_rd_colour <= '0;
      else if (r_fill1) r_rd_colour <= r_clr;
      else if (r_hit1)  r_rd_colour <= r_byp1;
      else              r_rd_colour <= w_ram_q;
    end
  end

  assign rd_colour  = r_rd_colour;
  assign busy       = (r_state == FILL);
  assign clear_done = (r_state == DONE);
endmodule

// File: tb/tb_screen_mirror.sv
// Directed bench for screen_mirror: vector table for reads/writes plus
// hand sequences for fills, reset-abort and pipeline ordering.
module tb_screen_mirror;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] wr_x, rd_x;
  logic [6:0] wr_y, rd_y;
  logic [2:0] wr_colour, rd_colour, clear_colour;
  logic       wr_en, clear_start, busy, clear_done;

  int n_tests = 0;
  int n_fail  = 0;

  screen_mirror dut (
    .clock(clock), .reset(reset),
    .wr_x(wr_x), .wr_y(wr_y), .wr_colour(wr_colour), .wr_en(wr_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] wx; logic [6:0] wy; logic [2:0] wc; logic we;
    logic [7:0] rx; logic [6:0] ry; logic [2:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // counts busy cycles until the fill ends; flags any clear_done seen meanwhile
  task automatic wait_fill(output int cnt, output bit early_done);
    cnt = 0;
    early_done = 1'b0;
    while (busy && cnt < 20000) begin
      if (clear_done) early_done = 1'b1;
      cnt++;
      tick();
    end
  endtask

  task automatic read_check(input string name, input logic [7:0] x,
                            input logic [6:0] y, input int exp);
    rd_x = x; rd_y = y;
    tick(); tick();
    check(name, rd_colour, exp);
  endtask

  initial begin
    int  cnt;
    bit  early;

    vecs[0]  = '{8'd10,  7'd5,   3'd5, 1'b1, 8'd10,  7'd5,   3'd5};
    vecs[1]  = '{8'd0,   7'd0,   3'd0, 1'b0, 8'd10,  7'd5,   3'd5};
    vecs[2]  = '{8'd0,   7'd0,   3'd0, 1'b0, 8'd11,  7'd5,   3'd0};
    vecs[3]  = '{8'd160, 7'd0,   3'd7, 1'b1, 8'd160, 7'd0,   3'd0};
    vecs[4]  = '{8'd0,   7'd0,   3'd0, 1'b0, 8'd0,   7'd0,   3'd0};
    vecs[5]  = '{8'd0,   7'd0,   3'd0, 1'b0, 8'd0,   7'd120, 3'd0};
    vecs[6]  = '{8'd159, 7'd119, 3'd6, 1'b1, 8'd159, 7'd119, 3'd6};
    vecs[7]  = '{8'd0,   7'd0,   3'd3, 1'b1, 8'd1,   7'd0,   3'd0};
    vecs[8]  = '{8'd0,   7'd0,   3'd0, 1'b0, 8'd0,   7'd0,   3'd3};
    vecs[9]  = '{8'd255, 7'd127, 3'd7, 1'b1, 8'd159, 7'd119, 3'd6};
    vecs[10] = '{8'd0,   7'd119, 3'd1, 1'b1, 8'd0,   7'd119, 3'd1};
    vecs[11] = '{8'd0,   7'd0,   3'd0, 1'b0, 8'd159, 7'd0,   3'd0};

    reset = 1'b1; wr_x = '0; wr_y = '0; wr_colour = '0; wr_en = 1'b0;
    rd_x = '0; rd_y = '0; clear_start = 1'b0; clear_colour = '0;
    tick();
    check("reset_rd_colour", rd_colour, 0);
    check("reset_busy", busy, 1);
    check("reset_clear_done", clear_done, 0);
    reset = 1'b0;

    // power-on fill
    wait_fill(cnt, early);
    check("init_fill_len", cnt, 19200);
    check("init_no_early_done", early, 0);
    check("init_done_pulse", clear_done, 1);
    tick();
    check("init_done_one_cycle", clear_done, 0);
    read_check("init_rd_0_0", 8'd0, 7'd0, 0);
    read_check("init_rd_159_119", 8'd159, 7'd119, 0);

    foreach (vecs[i]) begin
      wr_x = vecs[i].wx; wr_y = vecs[i].wy; wr_colour = vecs[i].wc;
      wr_en = vecs[i].we; rd_x = vecs[i].rx; rd_y = vecs[i].ry;
      tick();
      wr_en = 1'b0;
      tick();
      check($sformatf("vec%0d", i), rd_colour, vecs[i].exp);
    end

    // same-cycle write is visible, write one cycle later is not
    wr_x = 8'd20; wr_y = 7'd20; wr_colour = 3'b110; wr_en = 1'b1;
    rd_x = 8'd20; rd_y = 7'd20;
    tick();
    wr_colour = 3'b001; rd_x = 8'd0; rd_y = 7'd0;
    tick();
    wr_en = 1'b0;
    check("bypass_same_cycle", rd_colour, 3'b110);
    read_check("later_write_lands", 8'd20, 7'd20, 3'b001);

    // fill with 3'b010; coincident write and writes during FILL are dropped
    clear_start = 1'b1; clear_colour = 3'b010;
    wr_x = 8'd30; wr_y = 7'd30; wr_colour = 3'b111; wr_en = 1'b1;
    tick();
    clear_start = 1'b0; wr_en = 1'b0; clear_colour = 3'b101;
    cnt = 0; early = 1'b0;
    while (busy && cnt < 20000) begin
      if (clear_done) early = 1'b1;
      wr_en = 1'b0;
      if (cnt == 50) begin
        wr_x = 8'd0; wr_y = 7'd0; wr_colour = 3'b101; wr_en = 1'b1;
        clear_start = 1'b1;
      end else clear_start = 1'b0;
      if (cnt == 100) begin rd_x = 8'd159; rd_y = 7'd119; end
      if (cnt == 102) check("fill_read_during_busy", rd_colour, 3'b010);
      cnt++;
      tick();
    end
    wr_en = 1'b0; clear_start = 1'b0;
    check("fill_len", cnt, 19200);
    check("fill_no_early_done", early, 0);
    check("fill_done_pulse", clear_done, 1);
    // clear_start while DONE is ignored
    clear_start = 1'b1; clear_colour = 3'b101;
    tick();
    clear_start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    read_check("fill_rd_30_30", 8'd30, 7'd30, 3'b010);
    read_check("fill_rd_0_0", 8'd0, 7'd0, 3'b010);
    read_check("fill_rd_20_20", 8'd20, 7'd20, 3'b010);

    // reset 5000 cycles into a fill restarts it with colour 0
    clear_start = 1'b1; clear_colour = 3'b101;
    tick();
    clear_start = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (clear_done) early = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1);
    check("abort_rd_cleared", rd_colour, 0);
    wait_fill(cnt, early);
    check("abort_fill_len", cnt, 19200);
    check("abort_no_stale_done", early, 0);
    check("abort_done_pulse", clear_done, 1);
    read_check("abort_rd_0_0", 8'd0, 7'd0, 0);
    read_check("abort_rd_100_100", 8'd100, 7'd100, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
